dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time from the pipeline's `rd`/`wr`/`addr`/`wr_data` request signals and serves it from an internal word-organised RAM after a programmable number of wait states. It performs RV32I byte/half/word sizing and sign extension, and reports completion with a one-cycle `mem_ready` pulse, plus `mem_err` for misaligned or illegal accesses. It sits between the core's memory stage and the data RAM, and gives the pipeline a realistic variable-latency memory to stall against.

## Interface
- `DATA_W`, 32: data width; fixed at 32 for RV32.
- `ADDR_W`, 9: byte-address width; RAM depth is 2**ADDR_W/4 words (128).
- `WAIT_CYCLES`, 1: wait states inserted before the response; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_rd`  in  1  load request; held high until `mem_ready`.
- `mem_wr`  in  1  store request; held high until `mem_ready`.
- `mem_addr`  in  ADDR_W  byte address.
- `mem_funct3`  in  3  access size/sign (RV32I funct3 encoding).
- `mem_wdata`  in  DATA_W  store data, right-aligned.
- `mem_rdata`  out  DATA_W  load result, sized and extended; 0 for stores and errors.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  valid with `mem_ready`; the access was rejected.
- `busy`  out  1  high in WAIT and RESP.

## Operation
FSM states are IDLE, WAIT and RESP.
- **IDLE:** if `mem_rd | mem_wr` is high at an edge, latch addr, funct3, wdata and kind, and load the counter with WAIT_CYCLES.
  - Go to WAIT when WAIT_CYCLES > 0.
  - Otherwise execute the access and go directly to RESP.
- **WAIT:** decrement the counter each cycle. On the edge where the counter is 1, execute the access and enter RESP.
- **RESP:** `mem_ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- **Execute:** happens on the edge entering RESP.
  - Store: merge the lanes into the RAM word `addr[ADDR_W-1:2]`.
  - Load: register the sized result into `mem_rdata`.
- **Sizing:** byte lane is `addr[1:0]`.
  - 000 LB/SB; 001 LH/SH; 010 LW/SW.
  - 100 LBU and 101 LHU are zero-extended and valid for loads only.
- **Errors** (no RAM write, `mem_rdata`=0, `mem_err`=1 in RESP):
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Any other funct3.
  - `mem_rd` and `mem_wr` both high.
- Requests arriving while `busy` are ignored. The requester drops or changes its request in the cycle after `mem_ready`; the request is re-sampled in IDLE.
- RAM contents are not reset; initial contents are undefined (0 in simulation).

## Timing
- Reset values: state=IDLE, counter=0, `mem_rdata`=0, `mem_ready`=0, `mem_err`=0, `busy`=0.
- Latency: a request sampled at edge N gives `mem_ready` high in the cycle after edge N+WAIT_CYCLES. That is WAIT_CYCLES+1 cycles after sampling. Minimum is 1 cycle when WAIT_CYCLES=0.
- Throughput: one access per WAIT_CYCLES+2 cycles, because RESP→IDLE costs one cycle.
- `mem_rdata` and `mem_err` are registered and meaningful only while `mem_ready`=1. They are cleared to 0 on the edge leaving RESP.
- Reset mid-operation:
  - In WAIT, the access is aborted and no write occurs.
  - In RESP, the write has already committed and the response pulse is cut.
- Counter width is 4 bits, and the counter saturates at 0.

## Structure
- Package `dmem_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - `typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t`;
  - the access-kind typedef.
- Sub-module `lsu_align` is combinational. It contains:
  - store lane merge, taking old word, wdata, funct3 and addr[1:0] and returning the new word;
  - load extract/extend, taking word, funct3 and addr[1:0] and returning rdata;
  - the misalign/illegal flag.

  The FSM, counter and RAM stay in `dmem_responder`.

## Test plan
- **SW then LW, WAIT_CYCLES=1:** write 0xDEADBEEF at addr 0x010, then read 0x010.
  - Each access: `mem_ready` appears 2 cycles after sampling.
  - LW returns 0xDEADBEEF with `mem_err`=0.
- **Sizing and extension** on the word at 0x010 = 0xDEADBEEF:
  - LB 0x013 → 0xFFFFFFDE; LBU 0x013 → 0x000000DE.
  - LH 0x012 → 0xFFFFDEAD; LHU 0x010 → 0x0000BEEF.
- **Partial stores:** SB 0x55 to 0x011, then SH 0x1234 to 0x012. LW 0x010 → 0x123455EF.
- **Misaligned/illegal:**
  - LW 0x012 → `mem_err`=1, `mem_rdata`=0.
  - SH 0x013 → `mem_err`=1, and a following LW of 0x010 is unchanged.
  - rd and wr both high → `mem_err`=1.
- **Latency sweep:** WAIT_CYCLES=0 → ready 1 cycle after sampling; WAIT_CYCLES=15 → ready 16 cycles after sampling. `busy` is high throughout, and a second request held during `busy` is not accepted early.
- **Reset mid-operation:**
  - Assert `reset` during WAIT of SW 0xCAFEF00D to 0x020. All outputs go to 0 the next cycle, and a later LW 0x020 returns the old value.
  - Assert `reset` during RESP instead. The store persists.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef enum logic [1:0] {ACC_LOAD, ACC_STORE, ACC_BAD} acc_kind_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational RV32I lane merge for stores, extract/extend for loads, and access legality.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic        is_store_i,
  output logic [31:0] new_word_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] data;

  always_comb begin
    shifted    = old_word_i >> {lane_i, 3'b000};
    mask       = '0;
    data       = '0;
    rdata_o    = '0;
    err_o      = 1'b0;
    case (funct3_i)
      F3_B: begin
        mask    = 32'h0000_00FF << {lane_i, 3'b000};
        data    = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        err_o   = lane_i[0];
        mask    = 32'h0000_FFFF << {lane_i[1], 4'b0000};
        data    = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        err_o   = (lane_i != 2'b00);
        mask    = '1;
        data    = wdata_i;
        rdata_o = old_word_i;
      end
      F3_BU: begin
        err_o   = is_store_i;
        rdata_o = {24'h0, shifted[7:0]};
      end
      F3_HU: begin
        err_o   = is_store_i | lane_i[0];
        rdata_o = {16'h0, shifted[15:0]};
      end
      default: err_o = 1'b1;
    endcase
    new_word_o = (old_word_i & ~mask) | (data & mask);
  end

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder: IDLE/WAIT/RESP FSM over a word RAM with RV32I sizing.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  acc_kind_t         kind_q, kind_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [WORDS];

  acc_kind_t         in_kind, op_kind;
  logic [ADDR_W-1:0] op_addr;
  logic [2:0]        op_f3;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] old_word, new_word, ld_data;
  logic              align_err, acc_err, exec, ram_we;

  always_comb begin
    if (mem_rd && mem_wr) in_kind = ACC_BAD;
    else if (mem_wr)      in_kind = ACC_STORE;
    else                  in_kind = ACC_LOAD;
  end

  // With zero wait states the access executes on the sampling edge, so operands bypass the latches.
  assign op_addr  = (state_q == IDLE) ? mem_addr   : addr_q;
  assign op_f3    = (state_q == IDLE) ? mem_funct3 : f3_q;
  assign op_wdata = (state_q == IDLE) ? mem_wdata  : wdata_q;
  assign op_kind  = (state_q == IDLE) ? in_kind    : kind_q;
  assign old_word = mem_q[op_addr[ADDR_W-1:2]];

  lsu_align u_align (
    .old_word_i (old_word),
    .wdata_i    (op_wdata),
    .funct3_i   (op_f3),
    .lane_i     (op_addr[1:0]),
    .is_store_i (op_kind == ACC_STORE),
    .new_word_o (new_word),
    .rdata_o    (ld_data),
    .err_o      (align_err)
  );

  assign acc_err = align_err || (op_kind == ACC_BAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    kind_d  = kind_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          addr_d  = mem_addr;
          f3_d    = mem_funct3;
          wdata_d = mem_wdata;
          kind_d  = in_kind;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            exec    = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          exec    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (exec) begin
      err_d   = acc_err;
      rdata_d = (op_kind == ACC_LOAD && !acc_err) ? ld_data : '0;
    end
  end

  assign ram_we = exec && !reset && !acc_err && (op_kind == ACC_STORE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      kind_q  <= ACC_LOAD;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      kind_q  <= kind_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[op_addr[ADDR_W-1:2]] <= new_word;
  end

  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;
  assign mem_ready = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at WAIT_CYCLES of 1, 0 and 15.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd [3];
  logic        wr [3];
  logic [8:0]  addr [3];
  logic [2:0]  f3 [3];
  logic [31:0] wd [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err [3];
  logic        busy [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_rd(rd[0]), .mem_wr(wr[0]), .mem_addr(addr[0]),
    .mem_funct3(f3[0]), .mem_wdata(wd[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
    .mem_err(err[0]), .busy(busy[0]));

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_rd(rd[1]), .mem_wr(wr[1]), .mem_addr(addr[1]),
    .mem_funct3(f3[1]), .mem_wdata(wd[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
    .mem_err(err[1]), .busy(busy[1]));

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(15)) u_dut15 (
    .clk(clk), .reset(reset), .mem_rd(rd[2]), .mem_wr(wr[2]), .mem_addr(addr[2]),
    .mem_funct3(f3[2]), .mem_wdata(wd[2]), .mem_rdata(rdata[2]), .mem_ready(ready[2]),
    .mem_err(err[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request on instance d, holds it until ready, returns result and latency.
  // With meddle set, the held request's address/data are altered mid-wait.
  task automatic acc(input int d, input logic r, input logic w, input logic [8:0] a,
                     input logic [2:0] f, input logic [31:0] wdv, input logic meddle,
                     output logic [31:0] rdo, output logic eo, output int lat,
                     output logic bz);
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; f3[d] = f; wd[d] = wdv;
    lat = 0;
    bz  = 1'b1;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (!busy[d]) bz = 1'b0;
      if (meddle && lat == 5) begin
        addr[d] = a + 9'd4;
        wd[d]   = 32'h0BAD_BAD0;
      end
    end while (!ready[d] && lat < 40);
    rdo = rdata[d];
    eo  = err[d];
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(posedge clk);
  endtask

  logic [31:0] r;
  logic        e;
  logic        bz;
  int          lat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; f3[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, ready[0]}, 32'd0);
    chk("rst_busy",  {31'b0, busy[0]},  32'd0);
    chk("rst_err",   {31'b0, err[0]},   32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    reset = 1'b0;

    // SW/LW with one wait state
    acc(0, 1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 1'b0, r, e, lat, bz);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'b0, e}, 32'd0);
    chk("sw_rdata", r, 32'd0);
    acc(0, 1'b1, 1'b0, 9'h010, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("lw_lat", lat, 2);
    chk("lw_data", r, 32'hDEADBEEF);
    chk("lw_err", {31'b0, e}, 32'd0);

    acc(0, 1'b1, 1'b0, 9'h013, 3'b000, '0, 1'b0, r, e, lat, bz);
    chk("lb_013", r, 32'hFFFFFFDE);
    acc(0, 1'b1, 1'b0, 9'h013, 3'b100, '0, 1'b0, r, e, lat, bz);
    chk("lbu_013", r, 32'h000000DE);
    acc(0, 1'b1, 1'b0, 9'h012, 3'b001, '0, 1'b0, r, e, lat, bz);
    chk("lh_012", r, 32'hFFFFDEAD);
    acc(0, 1'b1, 1'b0, 9'h010, 3'b101, '0, 1'b0, r, e, lat, bz);
    chk("lhu_010", r, 32'h0000BEEF);

    acc(0, 1'b0, 1'b1, 9'h011, 3'b000, 32'h00000055, 1'b0, r, e, lat, bz);
    chk("sb_err", {31'b0, e}, 32'd0);
    acc(0, 1'b0, 1'b1, 9'h012, 3'b001, 32'h00001234, 1'b0, r, e, lat, bz);
    acc(0, 1'b1, 1'b0, 9'h010, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("partial_lw", r, 32'h123455EF);

    acc(0, 1'b1, 1'b0, 9'h012, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("lw_mis_err", {31'b0, e}, 32'd1);
    chk("lw_mis_data", r, 32'd0);
    acc(0, 1'b0, 1'b1, 9'h013, 3'b001, 32'h0000FFFF, 1'b0, r, e, lat, bz);
    chk("sh_mis_err", {31'b0, e}, 32'd1);
    acc(0, 1'b1, 1'b0, 9'h010, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("sh_mis_nowr", r, 32'h123455EF);
    acc(0, 1'b1, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, r, e, lat, bz);
    chk("rdwr_err", {31'b0, e}, 32'd1);
    acc(0, 1'b0, 1'b1, 9'h010, 3'b100, 32'h0, 1'b0, r, e, lat, bz);
    chk("sbu_err", {31'b0, e}, 32'd1);
    acc(0, 1'b1, 1'b0, 9'h010, 3'b011, 32'h0, 1'b0, r, e, lat, bz);
    chk("f3_011_err", {31'b0, e}, 32'd1);

    // Latency sweep
    acc(1, 1'b0, 1'b1, 9'h030, 3'b010, 32'hA5A5_5A5A, 1'b0, r, e, lat, bz);
    chk("w0_lat", lat, 1);
    acc(1, 1'b1, 1'b0, 9'h031, 3'b000, '0, 1'b0, r, e, lat, bz);
    chk("w0_lb", r, 32'h0000005A);
    acc(2, 1'b0, 1'b1, 9'h040, 3'b010, 32'h7654_3210, 1'b1, r, e, lat, bz);
    chk("w15_lat", lat, 16);
    chk("w15_busy", {31'b0, bz}, 32'd1);
    acc(2, 1'b1, 1'b0, 9'h040, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("w15_latched", r, 32'h7654_3210);
    acc(2, 1'b1, 1'b0, 9'h044, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("w15_ignored", r, 32'd0);

    // Reset during WAIT aborts the store
    acc(0, 1'b0, 1'b1, 9'h020, 3'b010, 32'h1111_1111, 1'b0, r, e, lat, bz);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 9'h020; f3[0] = 3'b010; wd[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    chk("rw_in_wait", {31'b0, busy[0]}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr[0] = 1'b0;
    chk("rw_ready", {31'b0, ready[0]}, 32'd0);
    chk("rw_busy",  {31'b0, busy[0]},  32'd0);
    chk("rw_err",   {31'b0, err[0]},   32'd0);
    chk("rw_rdata", rdata[0], 32'd0);
    @(posedge clk);
    acc(0, 1'b1, 1'b0, 9'h020, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("rw_old", r, 32'h1111_1111);

    // Reset during RESP keeps the store
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 9'h020; f3[0] = 3'b010; wd[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rr_in_resp", {31'b0, ready[0]}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr[0] = 1'b0;
    chk("rr_ready", {31'b0, ready[0]}, 32'd0);
    chk("rr_busy",  {31'b0, busy[0]},  32'd0);
    @(posedge clk);
    acc(0, 1'b1, 1'b0, 9'h020, 3'b010, '0, 1'b0, r, e, lat, bz);
    chk("rr_kept", r, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
